// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Write-enable encoding matches the pipeline's MemWriteM field.
package dmem_arb_pkg;

  localparam int WAIT_W = 8;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_WORD = 2'b01;
  localparam logic [1:0] WE_BYTE = 2'b10;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    FORCE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive cycles the loader has been refused.
// tc_next flags that this cycle's increment reaches the limit.
module arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc_next
);

  localparam logic [WAIT_W-1:0] MAX_V = WAIT_W'(MAX);

  logic [WAIT_W-1:0] cnt;
  logic [WAIT_W-1:0] cnt_inc;

  assign cnt_inc = cnt + 1'b1;
  assign tc_next = inc && (cnt_inc == MAX_V);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_V)) begin
      cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the M stage (P, priority)
// and the loader/debug port (L), with a starvation-bounded forced L slot.
//
//   state | meaning
//   ARB   | normal arbitration, P wins contention, L served when P idle
//   FORCE | L owns memory for one cycle, pipeline stalled if P requests
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WAIT   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p_req_i,
  input  logic [1:0]            p_we_i,
  input  logic [ADDR_WIDTH-1:0] p_addr_i,
  input  logic [DATA_WIDTH-1:0] p_wdata_i,
  output logic [DATA_WIDTH-1:0] p_rdata_o,
  output logic                  p_stall_o,
  input  logic                  l_valid_i,
  input  logic [1:0]            l_we_i,
  input  logic [ADDR_WIDTH-1:0] l_addr_i,
  input  logic [DATA_WIDTH-1:0] l_wdata_i,
  output logic                  l_ready_o,
  output logic [DATA_WIDTH-1:0] l_rdata_o,
  output logic                  l_rvalid_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [1:0]            mem_we_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  arb_state_t state;
  arb_state_t state_nxt;
  logic       in_force;
  logic       l_grant;
  logic       p_grant;
  logic       contend;
  logic       force_tc;

  assign in_force = (state == FORCE);

  // Reset gates every grant so nothing reaches memory while rst is high.
  assign l_grant = !rst && l_valid_i && (in_force || !p_req_i);
  assign p_grant = !rst && !in_force && p_req_i;
  assign contend = !rst && !in_force && l_valid_i && p_req_i;

  assign l_ready_o = l_grant;
  assign p_stall_o = !rst && in_force && p_req_i;
  assign p_rdata_o = mem_rdata_i;

  arb_starve_cnt #(
    .MAX (MAX_WAIT)
  ) u_starve_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (l_grant || in_force),
    .inc     (contend),
    .tc_next (force_tc)
  );

  assign state_nxt = (!in_force && force_tc) ? FORCE : ARB;

  always_comb begin
    mem_addr_o  = p_addr_i;
    mem_wdata_o = p_wdata_i;
    mem_we_o    = WE_NONE;
    if (l_grant) begin
      mem_addr_o  = l_addr_i;
      mem_wdata_o = l_wdata_i;
      mem_we_o    = l_we_i;
    end else if (p_grant) begin
      mem_we_o = p_we_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      l_rdata_o  <= '0;
      l_rvalid_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      l_rvalid_o <= l_grant && (l_we_i == WE_NONE);
      if (l_grant && (l_we_i == WE_NONE)) begin
        l_rdata_o <= mem_rdata_i;
      end
    end
  end

endmodule
